// File: rtl/ncore_normalizer.sv
// ncore_normalizer: collects one signed psum vector from each of NCORE cores and sums the
// absolute values of every element. From the bit length of that sum it picks a right-shift
// that makes every element fit in W_OUT bits. It then emits the vectors one core at a time,
// each element shifted right by that amount.
//
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   s_valid/s_ready - per-core capture handshake (s_ready only in COLLECT)
//   psum_in         - NCORE packed vectors of COL signed BW_PSUM-bit elements
//   m_valid/m_ready - output handshake for the normalized vector
//   m_core          - index of the core whose vector is on psum_norm
//   psum_norm       - COL signed W_OUT-bit normalized elements
//   busy            - high whenever the FSM is not in COLLECT
//
// Optional feature: define NORM_ROUND_EN to round to nearest (with saturation) instead of
// truncating the arithmetic shift.
module ncore_normalizer #(
  parameter int unsigned NCORE   = 2,
  parameter int unsigned COL     = 8,
  parameter int unsigned BW_PSUM = 11,
  parameter int unsigned W_OUT   = BW_PSUM,
  localparam int unsigned CW     = (NCORE > 1) ? $clog2(NCORE) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCORE-1:0]           s_valid,
  output logic [NCORE-1:0]           s_ready,
  input  logic [NCORE*COL*BW_PSUM-1:0] psum_in,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [CW-1:0]              m_core,
  output logic [COL*W_OUT-1:0]       psum_norm,
  output logic                       busy
);

  localparam int unsigned VW = COL * BW_PSUM;
  localparam int unsigned AW = BW_PSUM + $clog2(NCORE * COL);
  localparam int unsigned SW = $clog2(AW + 1);
  // Headroom so that element + rounding constant cannot wrap for any legal shift.
  localparam int unsigned RW = AW + 3;

  typedef enum logic [1:0] {StCollect, StSum, StShift, StEmit} state_e;

  state_e                   state_q, state_d;
  logic [NCORE-1:0]         cap_q, cap_d;
  logic [NCORE-1:0][VW-1:0] data_q, data_d;
  logic [AW-1:0]            acc_q, acc_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [CW-1:0]            core_q, core_d;
  logic [SW-1:0]            shift_q, shift_d;

  logic [AW-1:0]            abs_sum;
  logic [SW-1:0]            shift_calc;

  // Sum of |element| for the core selected by the SUM counter. The magnitude is kept
  // unsigned so |-2^(BW_PSUM-1)| is represented exactly.
  always_comb begin
    logic [BW_PSUM-1:0] elem;
    logic [BW_PSUM-1:0] mag;
    abs_sum = '0;
    elem    = '0;
    mag     = '0;
    for (int j = 0; j < int'(COL); j++) begin
      elem    = data_q[cnt_q][j*BW_PSUM +: BW_PSUM];
      mag     = elem[BW_PSUM-1] ? (~elem + 1'b1) : elem;
      abs_sum = abs_sum + AW'(mag);
    end
  end

  // Shift = max(0, msb + 2 - W_OUT); the +2 leaves one bit for sign and one of margin.
  always_comb begin
    int msb;
    msb = 0;
    for (int i = 0; i < int'(AW); i++) begin
      if (acc_q[i]) msb = i;
    end
    shift_calc = (msb + 2 > int'(W_OUT)) ? SW'(msb + 2 - int'(W_OUT)) : '0;
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    data_d  = data_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    core_d  = core_q;
    shift_d = shift_q;
    s_ready = '0;
    m_valid = 1'b0;
    unique case (state_q)
      StCollect: begin
        s_ready = ~cap_q;
        acc_d   = '0;
        cnt_d   = '0;
        for (int i = 0; i < int'(NCORE); i++) begin
          if (s_valid[i] && !cap_q[i]) begin
            data_d[i] = psum_in[i*VW +: VW];
            cap_d[i]  = 1'b1;
          end
        end
        if (&cap_d) state_d = StSum;
      end
      StSum: begin
        acc_d = acc_q + abs_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NCORE - 1)) begin
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        shift_d = shift_calc;
        core_d  = '0;
        state_d = StEmit;
      end
      StEmit: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (core_q == CW'(NCORE - 1)) begin
            core_d  = '0;
            cap_d   = '0;
            state_d = StCollect;
          end else begin
            core_d = core_q + 1'b1;
          end
        end
      end
      default: state_d = StCollect;
    endcase
  end

  // Normalized output for the vector currently addressed by m_core.
  always_comb begin
    logic [BW_PSUM-1:0]   elem;
    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] shr;
`ifdef NORM_ROUND_EN
    localparam logic signed [RW-1:0] MaxOut = RW'((1 << (W_OUT - 1)) - 1);
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] tmp;
    rnd = (shift_q != '0) ? $signed(RW'(1) << (shift_q - 1'b1)) : '0;
    tmp = '0;
`endif
    psum_norm = '0;
    elem      = '0;
    ext       = '0;
    shr       = '0;
    for (int j = 0; j < int'(COL); j++) begin
      elem = data_q[core_q][j*BW_PSUM +: BW_PSUM];
      ext  = {{(RW - BW_PSUM){elem[BW_PSUM-1]}}, elem};
`ifdef NORM_ROUND_EN
      tmp = ext + rnd;
      shr = tmp >>> shift_q;
      if (shr > MaxOut) shr = MaxOut;
`else
      shr = ext >>> shift_q;
`endif
      psum_norm[j*W_OUT +: W_OUT] = shr[W_OUT-1:0];
    end
  end

  assign busy   = (state_q != StCollect);
  assign m_core = core_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StCollect;
      cap_q   <= '0;
      data_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      core_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      core_q  <= core_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: tb/tb_ncore_normalizer.sv
module tb_ncore_normalizer;

  localparam int NCORE = 2;
  localparam int COL   = 8;
  localparam int BW    = 11;
  localparam int WO    = 8;

`ifdef NORM_ROUND_EN
  localparam bit Rnd = 1'b1;
`else
  localparam bit Rnd = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NCORE-1:0]          s_valid;
  logic [NCORE-1:0]          s_ready;
  logic [NCORE*COL*BW-1:0]   psum_in;
  logic                      m_valid;
  logic                      m_ready;
  logic                      m_core;
  logic [COL*WO-1:0]         psum_norm;
  logic                      busy;

  int checks = 0;
  int errors = 0;

  ncore_normalizer #(
    .NCORE  (NCORE),
    .COL    (COL),
    .BW_PSUM(BW),
    .W_OUT  (WO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .psum_in  (psum_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_core   (m_core),
    .psum_norm(psum_norm),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int c, input int v);
    for (int j = 0; j < COL; j++) psum_in[(c*COL+j)*BW +: BW] = BW'(v);
  endtask

  function automatic logic [63:0] rep(input int v);
    logic [63:0] r;
    for (int j = 0; j < COL; j++) r[j*WO +: WO] = WO'(v);
    return r;
  endfunction

  initial begin
    reset   = 1'b1;
    s_valid = '0;
    m_ready = 1'b0;
    psum_in = '0;
    step();
    chk("rst_s_ready", 64'(s_ready), 64'h3);
    chk("rst_m_valid", 64'(m_valid), 64'h0);
    chk("rst_m_core", 64'(m_core), 64'h0);
    chk("rst_psum_norm", psum_norm, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    reset = 1'b0;
    step();

    // All 120: sum 1920, shift 4 -> 7 (8 when rounding).
    set_core(0, 120);
    set_core(1, 120);
    s_valid = 2'b11;
    step();
    s_valid = 2'b00;
    chk("a_s_ready_sum", 64'(s_ready), 64'h0);
    chk("a_busy_sum", 64'(busy), 64'h1);
    chk("a_mvalid_t1", 64'(m_valid), 64'h0);
    step();
    step();
    chk("a_mvalid_t3", 64'(m_valid), 64'h0);
    step();
    chk("a_mvalid_t4", 64'(m_valid), 64'h1);
    chk("a_mcore0", 64'(m_core), 64'h0);
    chk("a_norm0", psum_norm, rep(Rnd ? 8 : 7));
    m_ready = 1'b1;
    step();
    chk("a_mcore1", 64'(m_core), 64'h1);
    chk("a_norm1", psum_norm, rep(Rnd ? 8 : 7));
    step();
    m_ready = 1'b0;
    chk("a_mvalid_done", 64'(m_valid), 64'h0);
    chk("a_busy_done", 64'(busy), 64'h0);
    chk("a_s_ready_done", 64'(s_ready), 64'h3);

    // Single -1024: shift 4 -> -64; plus 5-cycle stall in EMIT.
    set_core(0, 0);
    set_core(1, 0);
    psum_in[BW-1:0] = 11'h400;
    s_valid = 2'b11;
    step();
    s_valid = 2'b00;
    step();
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      chk("b_stall_mvalid", 64'(m_valid), 64'h1);
      chk("b_stall_mcore", 64'(m_core), 64'h0);
      chk("b_stall_norm", psum_norm, 64'h00000000000000C0);
      step();
    end
    m_ready = 1'b1;
    step();
    chk("b_mcore1", 64'(m_core), 64'h1);
    chk("b_norm1", psum_norm, 64'h0);
    step();
    m_ready = 1'b0;
    chk("b_busy_done", 64'(busy), 64'h0);

    // All zero: shift 0, outputs zero, back to COLLECT.
    psum_in = '0;
    s_valid = 2'b11;
    step();
    s_valid = 2'b00;
    step();
    step();
    step();
    chk("c_mvalid", 64'(m_valid), 64'h1);
    chk("c_norm0", psum_norm, 64'h0);
    m_ready = 1'b1;
    step();
    chk("c_mcore1", 64'(m_core), 64'h1);
    chk("c_norm1", psum_norm, 64'h0);
    step();
    m_ready = 1'b0;
    chk("c_busy_done", 64'(busy), 64'h0);
    chk("c_mvalid_done", 64'(m_valid), 64'h0);

    // Staggered capture: core1 at cycle 0 (100), core0 at cycle 3 (30).
    // Sum 1040 -> shift 4; core1 must not be recaptured with 50.
    set_core(1, 100);
    set_core(0, 0);
    s_valid = 2'b10;
    step();                           // cycle 1
    chk("d_s_ready_c1", 64'(s_ready), 64'h1);
    set_core(1, 50);
    step();                           // cycle 2
    step();                           // cycle 3
    set_core(0, 30);
    s_valid = 2'b11;
    step();                           // cycle 4
    s_valid = 2'b00;
    chk("d_s_ready_c4", 64'(s_ready), 64'h0);
    step();                           // cycle 5
    step();                           // cycle 6
    chk("d_mvalid_c6", 64'(m_valid), 64'h0);
    step();                           // cycle 7
    chk("d_mvalid_c7", 64'(m_valid), 64'h1);
    chk("d_norm0", psum_norm, rep(Rnd ? 2 : 1));
    m_ready = 1'b1;
    step();
    chk("d_norm1", psum_norm, rep(6));
    step();
    m_ready = 1'b0;

    // Reset between edges mid-SUM, then a fresh frame.
    set_core(0, 120);
    set_core(1, 120);
    s_valid = 2'b11;
    step();
    s_valid = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    chk("e_rst_busy", 64'(busy), 64'h0);
    chk("e_rst_s_ready", 64'(s_ready), 64'h3);
    chk("e_rst_m_valid", 64'(m_valid), 64'h0);
    chk("e_rst_psum_norm", psum_norm, 64'h0);
    reset = 1'b0;
    step();
    // core0 -200, core1 60: sum 2080 -> shift 5.
    set_core(0, -200);
    set_core(1, 60);
    s_valid = 2'b11;
    step();
    s_valid = 2'b00;
    step();
    step();
    step();
    chk("e_mvalid", 64'(m_valid), 64'h1);
    chk("e_norm0", psum_norm, rep(Rnd ? -6 : -7));
    m_ready = 1'b1;
    step();
    chk("e_norm1", psum_norm, rep(Rnd ? 2 : 1));
    step();
    m_ready = 1'b0;
    chk("e_busy_done", 64'(busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ncore_normalizer.md
NCORE_NORMALIZER -- requirements
Module: ncore_normalizer

Interface
REQ-001 SHALL have parameter NCORE, default 2: number of core psum channels (2..8).
REQ-002 SHALL have parameter COL, default 8: psum columns per core.
REQ-003 SHALL have parameter BW_PSUM, default 11: signed psum element width.
REQ-004 SHALL have parameter W_OUT, default BW_PSUM: signed normalized element width (4..BW_PSUM).
REQ-005 SHALL have port clk, input, 1: single clock; all state rising-edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port s_valid, input, NCORE: per-core psum vector valid.
REQ-008 SHALL have port s_ready, output, NCORE: per-core capture-slot free.
REQ-009 SHALL have port psum_in, input, NCORE*COL*BW_PSUM: core i occupies bits [(i+1)*COL*BW_PSUM-1 : i*COL*BW_PSUM].
REQ-010 SHALL have port m_valid, input-side handshake output, 1: normalized vector valid.
REQ-011 SHALL have port m_ready, input, 1: downstream accept.
REQ-012 SHALL have port m_core, output, max(1,clog2(NCORE)): index of core whose vector is on psum_norm.
REQ-013 SHALL have port psum_norm, output, COL*W_OUT: normalized vector, element j at bits [(j+1)*W_OUT-1 : j*W_OUT].
REQ-014 SHALL have port busy, output, 1: high in any state other than COLLECT.

Function
REQ-015 SHALL implement FSM states COLLECT, SUM, SHIFT, EMIT.
REQ-016 COLLECT: s_ready[i] = !captured[i]; core i's vector is latched and captured[i] set on s_valid[i] && s_ready[i]; simultaneous valids are all captured in the same cycle.
REQ-017 COLLECT -> SUM on the edge after which all captured[i] are set.
REQ-018 SUM: for NCORE cycles, the accumulator adds sum over j of |psum[c][j]|, c = 0..NCORE-1, one core per cycle; accumulator width BW_PSUM+clog2(NCORE*COL), never overflows; |-2^(BW_PSUM-1)| = 2^(BW_PSUM-1) exactly.
REQ-019 SHIFT (one cycle): msb = index of the highest set bit of the sum (0 if sum = 0); shift = max(0, msb+2-W_OUT).
REQ-020 EMIT: psum_norm element = psum >>> shift (arithmetic), truncated to W_OUT; the result always fits.
REQ-021 Latency: last capture at edge t -> m_valid high from cycle t+NCORE+2, with m_core = 0.
REQ-022 EMIT: m_valid stays high; m_core, psum_norm stable while !m_ready; on m_valid && m_ready, m_core increments.
REQ-023 Accept with m_core = NCORE-1 -> COLLECT, all captured cleared, m_valid low the next cycle.
REQ-024 s_ready SHALL be all-zero outside COLLECT; s_valid outside COLLECT SHALL be ignored.
REQ-025 m_valid SHALL be low outside EMIT.

Reset
REQ-026 On reset assertion, regardless of clk, SHALL enter COLLECT, clear captured, accumulator and m_core, and zero capture registers.
REQ-027 Reset outputs: s_ready all-ones, m_valid 0, m_core 0, psum_norm 0, busy 0; reset mid-SUM or mid-EMIT discards the frame.

Configuration
REQ-028 Macro NORM_ROUND_EN defined: when shift > 0, add 2^(shift-1) before the shift, saturating to 2^(W_OUT-1)-1.
REQ-029 NORM_ROUND_EN undefined: truncating arithmetic shift only, with no rounding logic.

Verification (NCORE=2, COL=8, BW_PSUM=11, W_OUT=8)
REQ-030 All 16 psums = 120, both valids at the same edge -> sum 1920, shift 4, all outputs 7 (8 with NORM_ROUND_EN), m_valid 4 cycles after capture.
REQ-031 Core0 element0 = -1024, all others 0 -> shift 4, output element0 = -64, rest 0, for m_core 0; m_core 1 gives all 0.
REQ-032 All psums 0 -> shift 0, both vectors output all 0, FSM returns to COLLECT.
REQ-033 s_valid[1] at cycle 0 and s_valid[0] at cycle 3 -> s_ready[1] low from cycle 1, core1 data not recaptured, first m_valid at cycle 7.
REQ-034 m_ready low for 5 cycles in EMIT -> m_valid, m_core, psum_norm held constant, then m_core 0 -> 1 on accept.
REQ-035 Reset pulsed mid-SUM, between edges -> outputs immediately at reset values; the next frame is normalized correctly.
